counter_sequencer: RTL

COUNTER_SEQUENCER -- requirements
Module: counter_sequencer

---
 rtl/counter_seq_pkg.sv | 17 +
 rtl/updown_wrap_cnt.sv | 34 +++
 rtl/counter_sequencer.sv | 126 ++++++++++++
 3 files changed

// File: rtl/counter_seq_pkg.sv
// Shared types and constants for the counter sequencer: FSM states,
// direction encoding and default widths.
package counter_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  localparam int DEF_CNT_W  = 3;
  localparam int DEF_STEP_W = 3;

endpackage

// File: rtl/updown_wrap_cnt.sv
// Up/down counter that wraps naturally at both ends; a synchronous clear
// has priority over the step strobes.
module updown_wrap_cnt
  import counter_seq_pkg::*;
#(
  parameter int W = DEF_CNT_W
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clr,
  input  logic         up,
  input  logic         down,
  output logic [W-1:0] value
);

  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] r_value;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_value <= '0;
    end else if (clr) begin
      r_value <= '0;
    end else if (up) begin
      r_value <= r_value + ONE;
    end else if (down) begin
      r_value <= r_value - ONE;
    end
  end

  assign value = r_value;

endmodule

// File: rtl/counter_sequencer.sv
// Two-requester command sequencer: accepts one up/down burst at a time,
// steps the wrapping counter once per cycle, then pulses completion.
module counter_sequencer
  import counter_seq_pkg::*;
#(
  parameter int CNT_W  = DEF_CNT_W,
  parameter int STEP_W = DEF_STEP_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req0_valid,
  input  logic              req0_dir,
  input  logic [STEP_W-1:0] req0_steps,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic              req1_dir,
  input  logic [STEP_W-1:0] req1_steps,
  output logic              req1_ready,
  input  logic              clr,
  output logic              busy,
  output logic              grant_id,
  output logic              done_valid,
  output logic [CNT_W-1:0]  count,
  output logic              cnt_up,
  output logic              cnt_down
);

  localparam logic [STEP_W:0] STEP_ONE = (STEP_W+1)'(1);

  state_t          r_state;
  state_t          w_nextState;
  logic            r_dir;
  logic            r_grant;
  logic            r_rrPrio;
  logic [STEP_W:0] r_remaining;
  logic            w_accept;
  logic            w_pick;
  logic            w_clrCnt;

  // r_rrPrio names the requester that wins when both are pending.
  always_comb begin
    w_pick = 1'b0;
    if (req0_valid && req1_valid) begin
      w_pick = r_rrPrio;
    end else if (req1_valid) begin
      w_pick = 1'b1;
    end
  end

  always_comb begin
    w_nextState = r_state;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    cnt_up      = 1'b0;
    cnt_down    = 1'b0;
    done_valid  = 1'b0;
    busy        = 1'b0;
    w_accept    = 1'b0;
    w_clrCnt    = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (clr) begin
          w_clrCnt = 1'b1;
        end else if (req0_valid || req1_valid) begin
          w_accept    = 1'b1;
          req0_ready  = !w_pick;
          req1_ready  = w_pick;
          w_nextState = ST_RUN;
        end
      end
      ST_RUN: begin
        busy     = 1'b1;
        cnt_up   = (r_dir == DIR_UP);
        cnt_down = (r_dir == DIR_DOWN);
        if (r_remaining == STEP_ONE) begin
          w_nextState = ST_DONE;
        end
      end
      ST_DONE: begin
        busy        = 1'b1;
        done_valid  = 1'b1;
        w_nextState = ST_IDLE;
      end
      default: begin
        w_nextState = ST_IDLE;
      end
    endcase
  end

  // The round-robin pointer only moves once a command has completed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_dir       <= DIR_DOWN;
      r_grant     <= 1'b0;
      r_rrPrio    <= 1'b0;
      r_remaining <= '0;
    end else begin
      r_state <= w_nextState;
      if (w_accept) begin
        r_grant     <= w_pick;
        r_dir       <= w_pick ? req1_dir : req0_dir;
        r_remaining <= {1'b0, (w_pick ? req1_steps : req0_steps)} + STEP_ONE;
      end else if (r_state == ST_RUN) begin
        r_remaining <= r_remaining - STEP_ONE;
      end
      if (r_state == ST_DONE) begin
        r_rrPrio <= ~r_grant;
      end
    end
  end

  assign grant_id = r_grant;

  updown_wrap_cnt #(
    .W(CNT_W)
  ) u_cnt (
    .clk    (clk),
    .reset_n(reset_n),
    .clr    (w_clrCnt),
    .up     (cnt_up),
    .down   (cnt_down),
    .value  (count)
  );

endmodule
